// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_if
// Description : Bundle between the EX stage and the multiply/divide unit.
//               The EX stage (master) issues MDStart/MDOp with the forwarded
//               rs/rt operands; the unit (slave) returns busy, the
//               architectural HI/LO registers and the mfhi/mflo read data.
// Ports       : start, md_op[3:0], src_a[31:0], src_b[31:0]  (EX -> unit)
//               busy, hi[31:0], lo[31:0], md_out[31:0]        (unit -> EX)
// Revision    : 1.0 - initial release
// ============================================================================
interface md_unit_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, hi, lo, md_out
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, hi, lo, md_out
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : EX-stage multiply/divide unit. Owns HI/LO, runs
//               mult/multu/div/divu with a fixed busy window so the hazard
//               unit can stall, and serves mfhi/mflo/mthi/mtlo.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous active-low reset
//               md     - md_unit_if.slave (start, md_op, src_a, src_b,
//                        busy, hi, lo, md_out)
// Parameters  : MULT_CYCLES - busy cycles for mult/multu (>=1)
//               DIV_CYCLES  - busy cycles for div/divu  (>=1)
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic clk,
    input  wire logic reset,
    md_unit_if.slave  md
);

    localparam int c_MAX_N  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // At least 4 bits; grows only when a parameter needs a load value above 15.
    localparam int c_CNT_W  = ($clog2(c_MAX_N) > 4) ? $clog2(c_MAX_N) : 4;

    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES - 1);

    localparam logic [3:0] c_OP_MULT  = 4'b0000;
    localparam logic [3:0] c_OP_MULTU = 4'b0001;
    localparam logic [3:0] c_OP_DIV   = 4'b0010;
    localparam logic [3:0] c_OP_DIVU  = 4'b0011;
    localparam logic [3:0] c_OP_MFHI  = 4'b0100;
    localparam logic [3:0] c_OP_MFLO  = 4'b0101;
    localparam logic [3:0] c_OP_MTHI  = 4'b0110;
    localparam logic [3:0] c_OP_MTLO  = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t               r_state, w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nx;
    logic [31:0]          r_hi,    w_hi_nx;
    logic [31:0]          r_lo,    w_lo_nx;
    logic [31:0]          r_pend_hi, w_pend_hi_nx;
    logic [31:0]          r_pend_lo, w_pend_lo_nx;
    logic                 r_pend_we, w_pend_we_nx;

    // Arithmetic datapath, evaluated from the live operands so the result
    // is captured on the accepting edge.
    logic [63:0]          w_prod_s;
    logic [63:0]          w_prod_u;
    logic [31:0]          w_div_b;
    logic signed [31:0]   w_quot_s;
    logic signed [31:0]   w_rem_s;
    logic [31:0]          w_quot_u;
    logic [31:0]          w_rem_u;

    assign w_prod_s = $signed({{32{md.src_a[31]}}, md.src_a}) *
                      $signed({{32{md.src_b[31]}}, md.src_b});
    assign w_prod_u = {32'd0, md.src_a} * {32'd0, md.src_b};

    // Divisor forced non-zero so the dividers never see /0; the pending
    // write is suppressed in that case anyway.
    assign w_div_b  = (md.src_b == 32'd0) ? 32'd1 : md.src_b;
    assign w_quot_s = $signed(md.src_a) / $signed(w_div_b);
    assign w_rem_s  = $signed(md.src_a) % $signed(w_div_b);
    assign w_quot_u = md.src_a / w_div_b;
    assign w_rem_u  = md.src_a % w_div_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_we <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_hi      <= w_hi_nx;
            r_lo      <= w_lo_nx;
            r_pend_hi <= w_pend_hi_nx;
            r_pend_lo <= w_pend_lo_nx;
            r_pend_we <= w_pend_we_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_hi_nx      = r_hi;
        w_lo_nx      = r_lo;
        w_pend_hi_nx = r_pend_hi;
        w_pend_lo_nx = r_pend_lo;
        w_pend_we_nx = r_pend_we;

        case (r_state)
            S_IDLE: begin
                if (md.start) begin
                    case (md.md_op)
                        c_OP_MULT: begin
                            w_pend_hi_nx = w_prod_s[63:32];
                            w_pend_lo_nx = w_prod_s[31:0];
                            w_pend_we_nx = 1'b1;
                            w_cnt_nx     = c_MULT_LOAD;
                            w_state_nx   = S_MULT;
                        end
                        c_OP_MULTU: begin
                            w_pend_hi_nx = w_prod_u[63:32];
                            w_pend_lo_nx = w_prod_u[31:0];
                            w_pend_we_nx = 1'b1;
                            w_cnt_nx     = c_MULT_LOAD;
                            w_state_nx   = S_MULT;
                        end
                        c_OP_DIV: begin
                            w_pend_hi_nx = w_rem_s;
                            w_pend_lo_nx = w_quot_s;
                            w_pend_we_nx = (md.src_b != 32'd0);
                            w_cnt_nx     = c_DIV_LOAD;
                            w_state_nx   = S_DIV;
                        end
                        c_OP_DIVU: begin
                            w_pend_hi_nx = w_rem_u;
                            w_pend_lo_nx = w_quot_u;
                            w_pend_we_nx = (md.src_b != 32'd0);
                            w_cnt_nx     = c_DIV_LOAD;
                            w_state_nx   = S_DIV;
                        end
                        c_OP_MTHI: w_hi_nx = md.src_a;
                        c_OP_MTLO: w_lo_nx = md.src_a;
                        default: ;
                    endcase
                end
            end
            S_MULT, S_DIV: begin
                // Any start seen here is dropped: the hazard unit stalls it.
                if (r_cnt == '0) begin
                    if (r_pend_we) begin
                        w_hi_nx = r_pend_hi;
                        w_lo_nx = r_pend_lo;
                    end
                    w_pend_we_nx = 1'b0;
                    w_state_nx   = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign md.busy = (r_state != S_IDLE);
    assign md.hi   = r_hi;
    assign md.lo   = r_lo;
    assign md.md_out = (md.md_op == c_OP_MFHI) ? r_hi :
                       (md.md_op == c_OP_MFLO) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_unit
// Description : Self-checking bench for md_unit. Expected HI/LO results are
//               queued when an operation is issued and compared when busy
//               drops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    md_unit_if u_if();

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.hi = h;
        e.lo = l;
        exp_q.push_back(e);
    endtask

    // Reference results {hi, lo} from wide-integer arithmetic.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        int              qa, qb;
        logic [63:0]     res;
        res = 64'd0;
        case (op)
            4'd0: begin sa = $signed(a); sb = $signed(b); res = sa * sb; end
            4'd1: begin ua = a; ub = b; res = ua * ub; end
            4'd2: begin qa = a; qb = b; res = {32'(qa % qb), 32'(qa / qb)}; end
            4'd3: res = {a % b, a / b};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Single-edge op (mthi/mtlo/reserved). Called #1 after a rising edge.
    task automatic pulse_op(input logic [3:0] op, input logic [31:0] a);
        u_if.start = 1'b1;
        u_if.md_op = op;
        u_if.src_a = a;
        @(posedge clk); #1;
        u_if.start = 1'b0;
    endtask

    // Issue a mult/div, count busy cycles, optionally inject a start while
    // busy, then pop the expected result and compare HI/LO.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input int inj_k,
                          input logic [3:0] inj_op, input logic [31:0] inj_a);
        logic [31:0] old_hi, old_lo;
        int          k;
        exp_t        e;
        old_hi = u_if.hi;
        old_lo = u_if.lo;
        u_if.start = 1'b1;
        u_if.md_op = op;
        u_if.src_a = a;
        u_if.src_b = b;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        k = 0;
        while (u_if.busy && k < 200) begin
            if (k == 0)
                check({tag, " md_out non-mf op"}, {32'd0, u_if.md_out}, 64'd0);
            if (k == n - 1)
                check({tag, " hi/lo held before done"}, {u_if.hi, u_if.lo}, {old_hi, old_lo});
            if (k == inj_k) begin
                u_if.start = 1'b1;
                u_if.md_op = inj_op;
                u_if.src_a = inj_a;
            end
            @(posedge clk); #1;
            u_if.start = 1'b0;
            u_if.md_op = op;
            k++;
        end
        check({tag, " busy cycles"}, 64'(k), 64'(n));
        if (exp_q.size() == 0) begin
            check({tag, " scoreboard entry present"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " hi"}, {32'd0, u_if.hi}, {32'd0, e.hi});
            check({tag, " lo"}, {32'd0, u_if.lo}, {32'd0, e.lo});
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] rexp;

        reset      = 1'b0;
        u_if.start = 1'b0;
        u_if.md_op = 4'd0;
        u_if.src_a = 32'd0;
        u_if.src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hi", {32'd0, u_if.hi}, 64'd0);
        check("reset lo", {32'd0, u_if.lo}, 64'd0);
        check("reset busy", {63'd0, u_if.busy}, 64'd0);
        check("reset md_out", {32'd0, u_if.md_out}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        push_exp(32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("mult", 4'd0, 32'hFFFFFFFF, 32'h2, 5, -1, 4'd0, 32'd0);
        push_exp(32'h00000001, 32'hFFFFFFFE);
        run_op("multu", 4'd1, 32'hFFFFFFFF, 32'h2, 5, -1, 4'd0, 32'd0);
        push_exp(32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div", 4'd2, 32'hFFFFFFF9, 32'h2, 10, -1, 4'd0, 32'd0);
        push_exp(32'h00000001, 32'h00000003);
        run_op("divu", 4'd3, 32'h7, 32'h2, 10, -1, 4'd0, 32'd0);

        // mthi then reads
        pulse_op(4'd6, 32'h12345678);
        check("mthi busy", {63'd0, u_if.busy}, 64'd0);
        check("mthi hi/lo", {u_if.hi, u_if.lo}, {32'h12345678, 32'h00000003});
        u_if.md_op = 4'd4; #1;
        check("mfhi md_out", {32'd0, u_if.md_out}, {32'd0, 32'h12345678});
        u_if.md_op = 4'd5; #1;
        check("mflo md_out", {32'd0, u_if.md_out}, {32'd0, 32'h00000003});

        // Divide by zero leaves HI/LO alone
        pulse_op(4'd6, 32'hAAAA0000);
        pulse_op(4'd7, 32'h0000BBBB);
        push_exp(32'hAAAA0000, 32'h0000BBBB);
        run_op("div0", 4'd2, 32'h1234, 32'h0, 10, -1, 4'd0, 32'd0);

        // mtlo while busy, and a start on the completion edge, are dropped
        push_exp(32'd2, 32'd14);
        run_op("div+mtlo", 4'd2, 32'd100, 32'd7, 10, 3, 4'd7, 32'hDEADBEEF);
        push_exp(32'd1, 32'd33);
        run_op("divu+mtlo@done", 4'd3, 32'd100, 32'd3, 10, 9, 4'd7, 32'hCAFEF00D);

        // Reserved opcode does nothing
        pulse_op(4'd8, 32'h55555555);
        check("reserved busy", {63'd0, u_if.busy}, 64'd0);
        check("reserved hi/lo", {u_if.hi, u_if.lo}, {32'd1, 32'd33});

        // Random operations against the reference model
        for (int i = 0; i < 6; i++) begin
            rop = 4'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            if (ra == 32'h80000000) ra = 32'd1;
            rexp = model(rop, ra, rb);
            push_exp(rexp[63:32], rexp[31:0]);
            run_op("random", rop, ra, rb, (rop < 4'd2) ? 5 : 10, -1, 4'd0, 32'd0);
        end

        // Back-to-back: div issued the first cycle after the mult finishes
        push_exp(32'd0, 32'd12);
        run_op("b2b mult", 4'd0, 32'd3, 32'd4, 5, -1, 4'd0, 32'd0);
        push_exp(32'hFFFFFFFE, 32'hFFFFFFFA);
        run_op("b2b div", 4'd2, 32'hFFFFFFEC, 32'd3, 10, -1, 4'd0, 32'd0);

        // mfhi while busy, then asynchronous reset aborts the mult
        u_if.start = 1'b1;
        u_if.md_op = 4'd0;
        u_if.src_a = 32'd3;
        u_if.src_b = 32'd3;
        @(posedge clk); #1;
        u_if.start = 1'b0;
        u_if.md_op = 4'd4; #1;
        check("mfhi while busy", {31'd0, u_if.busy, u_if.md_out}, {31'd0, 1'b1, 32'hFFFFFFFE});
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async reset hi/lo", {u_if.hi, u_if.lo}, 64'd0);
        check("async reset busy", {63'd0, u_if.busy}, 64'd0);
        #3 reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("no late write hi/lo", {u_if.hi, u_if.lo}, 64'd0);
        check("no late write busy", {63'd0, u_if.busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
